// File: rtl/mem_bus_responder.sv
// Target side of the external memory bus: single and 4-beat wrapping
// bursts with programmable wait states, driving a 1-cycle-latency SRAM.
module mem_bus_responder #(
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 2,
  parameter int CNT_W       = 4
) (
  input  logic              ph1,
  input  logic              reset_b,
  input  logic              req,
  input  logic              rw,
  input  logic              burst,
  input  logic [31:0]       adr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        bytemask,
  output logic              ack,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam logic [CNT_W-1:0] WLOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [1:0]        beat_q, beat_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic              rw_q, rw_d;
  logic              burst_q, burst_d;

  // Byte offset and aliased high address bits are deliberately dropped.
  logic unused_adr;
  assign unused_adr = ^{adr[31:MEM_AW+2], adr[1:0]};

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      rw_q    <= 1'b0;
      burst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      rw_q    <= rw_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    beat_d    = beat_q;
    base_d    = base_q;
    rw_d      = rw_q;
    burst_d   = burst_q;
    ack       = 1'b0;
    done      = 1'b0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    mem_be    = '0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          base_d  = adr[MEM_AW+1:2];
          rw_d    = rw;
          burst_d = burst;
          beat_d  = '0;
          if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WLOAD;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = rw_q;
        // Low two bits wrap so bursts stay inside the 16-byte line.
        mem_adr   = {base_q[MEM_AW-1:2], base_q[1:0] + beat_q};
        mem_wdata = rw_q ? wdata : '0;
        mem_be    = rw_q ? bytemask : 4'b1111;
        state_d   = S_RESP;
      end
      S_RESP: begin
        ack   = 1'b1;
        rdata = rw_q ? '0 : mem_rdata;
        if (!burst_q || beat_q == 2'd3) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_q + 1'b1;
          state_d = S_ACCESS;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: two responders (2 and 0 wait states), each with its
// own behavioural SRAM.
module tb_mem_bus_responder;

  logic        ph1 = 1'b0;
  logic        reset_b;
  logic        req, rw, burst, sel;
  logic [31:0] adr, wdata;
  logic [3:0]  bm;

  logic        ack0, done0, busy0, en0, we0;
  logic [9:0]  madr0;
  logic [31:0] rdat0, mwd0, mrd0;
  logic [3:0]  mbe0;
  logic        ack1, done1, busy1, en1, we1;
  logic [9:0]  madr1;
  logic [31:0] rdat1, mwd1, mrd1;
  logic [3:0]  mbe1;
  logic        req0, req1;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];

  int checks = 0;
  int errors = 0;

  logic [31:0] wd_v [4];
  int          acc_cyc [4];
  logic [31:0] acc_adr [4];
  logic        acc_we [4];
  int          ack_cyc [4];
  logic [31:0] ack_dat [4];
  logic        ack_done [4];
  int          n_acc, n_ack, cyc;
  logic        bz;

  always #5 ph1 = ~ph1;

  assign req0 = req & ~sel;
  assign req1 = req & sel;

  mem_bus_responder #(.MEM_AW(10), .WAIT_STATES(2), .CNT_W(4)) u0 (
    .ph1(ph1), .reset_b(reset_b), .req(req0), .rw(rw), .burst(burst),
    .adr(adr), .wdata(wdata), .bytemask(bm), .ack(ack0), .done(done0),
    .rdata(rdat0), .busy(busy0), .mem_en(en0), .mem_we(we0),
    .mem_adr(madr0), .mem_wdata(mwd0), .mem_be(mbe0), .mem_rdata(mrd0)
  );

  mem_bus_responder #(.MEM_AW(10), .WAIT_STATES(0), .CNT_W(4)) u1 (
    .ph1(ph1), .reset_b(reset_b), .req(req1), .rw(rw), .burst(burst),
    .adr(adr), .wdata(wdata), .bytemask(bm), .ack(ack1), .done(done1),
    .rdata(rdat1), .busy(busy1), .mem_en(en1), .mem_we(we1),
    .mem_adr(madr1), .mem_wdata(mwd1), .mem_be(mbe1), .mem_rdata(mrd1)
  );

  always @(posedge ph1) begin
    if (en0) begin
      if (we0) begin
        for (int i = 0; i < 4; i++)
          if (mbe0[i]) mem0[madr0][8*i +: 8] <= mwd0[8*i +: 8];
      end else begin
        mrd0 <= mem0[madr0];
      end
    end
  end

  always @(posedge ph1) begin
    if (en1) begin
      if (we1) begin
        for (int i = 0; i < 4; i++)
          if (mbe1[i]) mem1[madr1][8*i +: 8] <= mwd1[8*i +: 8];
      end else begin
        mrd1 <= mem1[madr1];
      end
    end
  end

  logic        s_ack, s_done, s_busy, s_en, s_we;
  logic [9:0]  s_adr;
  logic [31:0] s_rdata;
  assign s_ack   = sel ? ack1  : ack0;
  assign s_done  = sel ? done1 : done0;
  assign s_busy  = sel ? busy1 : busy0;
  assign s_en    = sel ? en1   : en0;
  assign s_we    = sel ? we1   : we0;
  assign s_adr   = sel ? madr1 : madr0;
  assign s_rdata = sel ? rdat1 : rdat0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic s, input logic w, input logic b,
                      input logic [31:0] a);
    int  c;
    logic fin;
    @(negedge ph1);
    sel   = s;
    rw    = w;
    burst = b;
    adr   = a;
    wdata = wd_v[0];
    req   = 1'b1;
    n_acc = 0;
    n_ack = 0;
    c     = 0;
    fin   = 1'b0;
    while (!fin && c < 40) begin
      @(negedge ph1);
      c++;
      if (s_en && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        acc_adr[n_acc] = 32'(s_adr);
        acc_we[n_acc]  = s_we;
        n_acc++;
      end
      if (s_ack && n_ack < 4) begin
        ack_cyc[n_ack]  = c;
        ack_dat[n_ack]  = s_rdata;
        ack_done[n_ack] = s_done;
        n_ack++;
        if (n_ack < 4) wdata = wd_v[n_ack];
        if (s_done) fin = 1'b1;
      end
    end
    req = 1'b0;
    if (!fin) check("xfer_timeout", 32'(fin), 32'd1);
  endtask

  logic [31:0] exp_seq [4];

  initial begin
    reset_b = 1'b0;
    req = 1'b0; rw = 1'b0; burst = 1'b0; sel = 1'b0;
    adr = '0; wdata = '0; bm = 4'hf;
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    repeat (3) @(negedge ph1);
    check("rst_outs",
          {ack0, done0, busy0, en0, we0, ack1, done1, busy1, en1, we1}, 0);
    reset_b = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge ph1);
      check("idle_ctl",
            {ack0, done0, busy0, en0, we0, ack1, done1, busy1, en1, we1}, 0);
      if (i == 19) begin
        check("idle_data0", rdat0 | mwd0 | 32'(madr0) | 32'(mbe0), 0);
        check("idle_data1", rdat1 | mwd1 | 32'(madr1) | 32'(mbe1), 0);
      end
    end

    wd_v[0] = 32'hDEADBEEF;
    bm = 4'hf;
    xfer(1'b0, 1'b1, 1'b0, 32'h40);
    check("wr_acc_cyc", 32'(acc_cyc[0]), 3);
    check("wr_acc_adr", acc_adr[0], 32'h10);
    check("wr_acc_we", 32'(acc_we[0]), 1);
    check("wr_ack_cyc", 32'(ack_cyc[0]), 4);
    check("wr_done", 32'(ack_done[0]), 1);
    check("wr_rdata0", ack_dat[0], 0);

    xfer(1'b0, 1'b0, 1'b0, 32'h40);
    check("rd_ack_cyc", 32'(ack_cyc[0]), 4);
    check("rd_done", 32'(ack_done[0]), 1);
    check("rd_data", ack_dat[0], 32'hDEADBEEF);
    check("rd_acc_we", 32'(acc_we[0]), 0);

    mem0[10'h10] = 32'h11223344;
    wd_v[0] = 32'hAABBCCDD;
    bm = 4'b0101;
    xfer(1'b0, 1'b1, 1'b0, 32'h40);
    bm = 4'hf;
    xfer(1'b0, 1'b0, 1'b0, 32'h40);
    check("bm_data", ack_dat[0], 32'h11BB33DD);

    for (int i = 0; i < 4; i++) mem0[10'h40 + i] = 32'hA0 + 32'(i);
    xfer(1'b0, 1'b0, 1'b1, 32'h108);
    check("br_nacc", 32'(n_acc), 4);
    check("br_nack", 32'(n_ack), 4);
    exp_seq[0] = 32'h42; exp_seq[1] = 32'h43;
    exp_seq[2] = 32'h40; exp_seq[3] = 32'h41;
    for (int i = 0; i < 4; i++) begin
      check("br_adr", acc_adr[i], exp_seq[i]);
      check("br_data", ack_dat[i], exp_seq[i] + 32'h60);
      check("br_ack_cyc", 32'(ack_cyc[i]), 32'(4 + 2 * i));
      check("br_done", 32'(ack_done[i]), (i == 3) ? 32'd1 : 32'd0);
    end

    mem1[5] = 32'h0000_0055;
    mem1[6] = 32'h0000_0066;
    @(negedge ph1);
    sel = 1'b1; rw = 1'b0; burst = 1'b0; adr = 32'h14; req = 1'b1;
    cyc = 0; n_ack = 0; bz = 1'b1;
    while (n_ack < 2 && cyc < 30) begin
      @(negedge ph1);
      cyc++;
      if (cyc == 3) bz = busy1;
      if (ack1) begin
        ack_cyc[n_ack] = cyc;
        ack_dat[n_ack] = rdat1;
        n_ack++;
        adr = 32'h18;
      end
    end
    req = 1'b0;
    check("b2b_nack", 32'(n_ack), 2);
    check("b2b_ack0_cyc", 32'(ack_cyc[0]), 2);
    check("b2b_ack1_cyc", 32'(ack_cyc[1]), 5);
    check("b2b_data0", ack_dat[0], 32'h55);
    check("b2b_data1", ack_dat[1], 32'h66);
    check("b2b_idle_gap", 32'(bz), 0);
    sel = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mem0[10'h80 + i] = '0;
      wd_v[i] = 32'h5000_0000 + 32'(i);
    end
    @(negedge ph1);
    sel = 1'b0; rw = 1'b1; burst = 1'b1; adr = 32'h208; bm = 4'hf;
    wdata = wd_v[0]; req = 1'b1;
    cyc = 0; n_ack = 0;
    while (n_ack < 2 && cyc < 40) begin
      @(negedge ph1);
      cyc++;
      if (ack0) begin
        n_ack++;
        wdata = wd_v[n_ack];
      end
    end
    check("ra_pre_acks", 32'(n_ack), 2);
    @(posedge ph1);
    #2;
    check("ra_pre_en", 32'(en0), 1);
    reset_b = 1'b0;
    #1;
    check("ra_drop", {30'd0, en0, we0}, 0);
    check("ra_idle", {30'd0, busy0, ack0}, 0);
    req = 1'b0;
    @(negedge ph1);
    @(negedge ph1);
    reset_b = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ph1);
      if (ack0 || en0 || busy0) n_ack++;
    end
    check("ra_quiet", 32'(n_ack), 0);
    check("ra_mem82", mem0[10'h82], 32'h5000_0000);
    check("ra_mem83", mem0[10'h83], 32'h5000_0001);
    check("ra_mem80", mem0[10'h80], 0);
    xfer(1'b0, 1'b0, 1'b0, 32'h208);
    check("ra_rd_cyc", 32'(ack_cyc[0]), 4);
    check("ra_rd_data", ack_dat[0], 32'h5000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
